// File: rtl/led_anim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_anim_ctrl
//  Purpose  : Write-only LED bank controller on the memorio bus. Holds a
//             24-bit pattern and shows it statically or through a blink /
//             rotate / sweep sequencer paced by a tick prescaler and a
//             programmable step period.
//  Revision : 1.0  initial release
// ============================================================================
module led_anim_ctrl #(
  parameter int TICK_DIV = 50000,  // led_clk cycles per timer tick (>= 1)
  parameter int PERIOD_W = 16      // width of the step-period register
) (
  input  logic        led_clk,
  input  logic        ledrst,
  input  logic        ledwrite,
  input  logic        ledcs,
  input  logic [1:0]  ledaddr,
  input  logic [15:0] ledwdata,
  output logic [23:0] ledout
);

  // A single-cycle tick still needs a 1-bit prescaler register.
  localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  localparam logic [1:0] ADDR_PAT_LO = 2'b00;
  localparam logic [1:0] ADDR_CTRL   = 2'b01;
  localparam logic [1:0] ADDR_PAT_HI = 2'b10;
  localparam logic [1:0] ADDR_PERIOD = 2'b11;

  typedef enum logic [2:0] {
    ST_STATIC    = 3'd0,
    ST_BLINK_ON  = 3'd1,
    ST_BLINK_OFF = 3'd2,
    ST_ROTATE    = 3'd3,
    ST_SWEEP_L   = 3'd4,
    ST_SWEEP_R   = 3'd5
  } state_t;

  state_t              state_q;
  logic [23:0]         pattern_q;
  logic [23:0]         pattern_d;
  logic [23:0]         work_q;
  logic [23:0]         ledout_q;
  logic                pause_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PRE_W-1:0]    presc_q;
  logic [PERIOD_W-1:0] cnt_q;

  logic        wr_en;
  logic        wr_pat_lo;
  logic        wr_pat_hi;
  logic        wr_ctrl;
  logic        wr_period;
  logic        tick;
  logic        step;
  logic [23:0] rot_d;
  logic [23:0] shl_d;
  logic [23:0] shr_d;

  assign ledout = ledout_q;

  // Bus decode, merged pattern, timer tick/step and shifted work values.
  always_comb begin
    wr_en     = ledcs & ledwrite;
    wr_pat_lo = wr_en && (ledaddr == ADDR_PAT_LO);
    wr_pat_hi = wr_en && (ledaddr == ADDR_PAT_HI);
    wr_ctrl   = wr_en && (ledaddr == ADDR_CTRL);
    wr_period = wr_en && (ledaddr == ADDR_PERIOD);

    pattern_d = pattern_q;
    if (wr_pat_lo) pattern_d[15:0]  = ledwdata;
    if (wr_pat_hi) pattern_d[23:16] = ledwdata[7:0];

    tick = !pause_q && (presc_q == PRE_LAST);
    // A CTRL or PERIOD write restarts the timer, so a coinciding step is dropped.
    step = tick && (cnt_q == period_q) && !(wr_ctrl || wr_period);

    rot_d = {work_q[22:0], work_q[23]};
    shl_d = {work_q[22:0], 1'b0};
    shr_d = {1'b0, work_q[23:1]};
  end

  // Pattern, pause and period registers.
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      pattern_q <= '0;
      pause_q   <= 1'b0;
      period_q  <= '0;
    end else begin
      pattern_q <= pattern_d;
      if (wr_ctrl)   pause_q  <= ledwdata[2];
      if (wr_period) period_q <= PERIOD_W'(ledwdata);
    end
  end

  // Prescaler and step counter; both frozen while paused, cleared on CTRL/PERIOD writes.
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else if (wr_ctrl || wr_period) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else if (!pause_q) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) cnt_q <= (cnt_q == period_q) ? '0 : cnt_q + 1'b1;
    end
  end

  // Animation sequencer with registered LED drive.
  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      state_q  <= ST_STATIC;
      work_q   <= '0;
      ledout_q <= '0;
    end else if (wr_ctrl) begin
      case (ledwdata[1:0])
        2'd0: begin
          state_q  <= ST_STATIC;
          work_q   <= pattern_q;
          ledout_q <= pattern_q;
        end
        2'd1: begin
          state_q  <= ST_BLINK_ON;
          work_q   <= pattern_q;
          ledout_q <= pattern_q;
        end
        2'd2: begin
          state_q  <= ST_ROTATE;
          work_q   <= pattern_q;
          ledout_q <= pattern_q;
        end
        default: begin
          state_q  <= ST_SWEEP_L;
          work_q   <= 24'h000001;
          ledout_q <= 24'h000001;
        end
      endcase
    end else begin
      case (state_q)
        ST_STATIC: begin
          ledout_q <= pattern_d;
        end
        ST_BLINK_ON: begin
          if (step) begin
            state_q  <= ST_BLINK_OFF;
            ledout_q <= 24'h000000;
          end
        end
        ST_BLINK_OFF: begin
          if (step) begin
            state_q  <= ST_BLINK_ON;
            ledout_q <= work_q;
          end
        end
        ST_ROTATE: begin
          if (step) begin
            work_q   <= rot_d;
            ledout_q <= rot_d;
          end
        end
        ST_SWEEP_L: begin
          if (step) begin
            if (work_q[23]) begin
              state_q  <= ST_SWEEP_R;
              work_q   <= shr_d;
              ledout_q <= shr_d;
            end else begin
              work_q   <= shl_d;
              ledout_q <= shl_d;
            end
          end
        end
        ST_SWEEP_R: begin
          if (step) begin
            if (work_q[0]) begin
              state_q  <= ST_SWEEP_L;
              work_q   <= shl_d;
              ledout_q <= shl_d;
            end else begin
              work_q   <= shr_d;
              ledout_q <= shr_d;
            end
          end
        end
        default: begin
          state_q <= ST_STATIC;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
